// File: rtl/hazard_control_unit_if.sv
// Bundles the hazard controller's pipeline-facing signals.
// The slave modport is the controller's view; master is the pipeline/driver view.
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ID_Jump;
  logic             ID_Branch;
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             UseShamt;
  logic             UseImmed;
  logic             EX_MemRead;
  logic [4:0]       EX_Rw;
  logic             EX_BranchTaken;
  logic             PCWrite;
  logic             IFWrite;
  logic             IFFlush;
  logic             Bubble;
  logic [1:0]       AddrSel;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCycles;

  modport slave (
    input  ID_Jump, ID_Branch, ID_Rs, ID_Rt, UseShamt, UseImmed,
           EX_MemRead, EX_Rw, EX_BranchTaken,
    output PCWrite, IFWrite, IFFlush, Bubble, AddrSel, StallCycles, FlushCycles
  );

  modport master (
    output ID_Jump, ID_Branch, ID_Rs, ID_Rt, UseShamt, UseImmed,
           EX_MemRead, EX_Rw, EX_BranchTaken,
    input  PCWrite, IFWrite, IFFlush, Bubble, AddrSel, StallCycles, FlushCycles
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use stall, jump/branch redirect and IF/ID flush control for the 5-stage MIPS pipe,
// with saturating stall/flush cycle counters for performance debug.
module hazard_control_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  Reset_L,
  hazard_control_unit_if.slave  bus
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_BR_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       rs_hit, rt_hit, load_use;
  logic       stall_evt;
  logic       pc_write, if_write, if_flush, bubble;
  logic [1:0] addr_sel;

  always_comb begin
    rs_hit   = (bus.EX_Rw == bus.ID_Rs) && !bus.UseShamt;
    rt_hit   = (bus.EX_Rw == bus.ID_Rt) && !bus.UseImmed;
    load_use = bus.EX_MemRead && (bus.EX_Rw != '0) && (rs_hit || rt_hit);
  end

  // Defaults are the stall/reset values; each branch of the decode only lists what differs.
  always_comb begin
    pc_write  = 1'b0;
    if_write  = 1'b0;
    if_flush  = 1'b0;
    bubble    = 1'b1;
    addr_sel  = 2'b00;
    stall_evt = 1'b0;
    state_d   = state_q;
    if (!Reset_L) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (load_use) begin
            stall_evt = 1'b1;
          end else if (bus.ID_Jump) begin
            pc_write = 1'b1;
            if_write = 1'b1;
            if_flush = 1'b1;
            bubble   = 1'b0;
            addr_sel = 2'b01;
          end else if (bus.ID_Branch) begin
            if_write = 1'b1;
            if_flush = 1'b1;
            bubble   = 1'b0;
            state_d  = S_BR_WAIT;
          end else begin
            pc_write = 1'b1;
            if_write = 1'b1;
            bubble   = 1'b0;
          end
        end
        S_BR_WAIT: begin
          pc_write = 1'b1;
          if_write = 1'b1;
          bubble   = 1'b0;
          state_d  = S_IDLE;
          if (bus.EX_BranchTaken) begin
            if_flush = 1'b1;
            addr_sel = 2'b10;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (if_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q     <= S_IDLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IFWrite     = if_write;
  assign bus.IFFlush     = if_flush;
  assign bus.Bubble      = bubble;
  assign bus.AddrSel     = addr_sel;
  assign bus.StallCycles = stall_cnt_q;
  assign bus.FlushCycles = flush_cnt_q;

endmodule
